uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning character width (legal 5..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit buffer entries (power of two, >=2).
REQ-003 SHALL have parameter CLK_DIV, default 434, meaning clock cycles per bit (>=2).
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-006 SHALL have port clk  in  1  single system clock; all logic rising-edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port wr_en  in  1  write request.
REQ-009 SHALL have port wr_data  in  DATA_BITS  character to queue.
REQ-010 SHALL have port full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-011 SHALL have port empty  out  1  FIFO holds zero entries.
REQ-012 SHALL have port count  out  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-013 SHALL have port overflow  out  1  sticky: write attempted while full.
REQ-014 SHALL have port busy  out  1  frame in progress.
REQ-015 SHALL have port tx_done  out  1  one-cycle pulse at end of each frame.
REQ-016 SHALL have port txd  out  1  serial line, idle high.

Function
REQ-017 SHALL accept a write when wr_en=1 and full=0; entry visible (empty=0, count+1) the following cycle.
REQ-018 SHALL ignore wr_en while full=1, including a cycle in which the FSM pops; overflow sets and holds until rst.
REQ-019 SHALL, on simultaneous accepted write and pop, keep count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-020 SHALL implement FSM states IDLE, START, DATA, PAR, STOP.
REQ-021 SHALL in IDLE drive txd=1, busy=0; if empty=0, pop head into shift register and enter START next cycle.
REQ-022 SHALL in START drive txd=0 for exactly CLK_DIV cycles, then DATA.
REQ-023 SHALL in DATA drive DATA_BITS bits LSB first, each exactly CLK_DIV cycles, then PAR if PARITY!=0 else STOP.
REQ-024 SHALL in PAR drive XOR of data bits (even) or its inverse (odd) for CLK_DIV cycles, then STOP.
REQ-025 SHALL in STOP drive txd=1 for STOP_BITS*CLK_DIV cycles, pulse tx_done in its final cycle, then IDLE.
REQ-026 SHALL run the bit counter 0..CLK_DIV-1 only outside IDLE, cleared on entering START.
REQ-027 SHALL give latency: write in cycle N onto empty idle block -> txd falls at cycle N+2; back-to-back frames separated by exactly one IDLE cycle.
REQ-028 SHALL assert busy in every state except IDLE; txd registered, glitch-free.

Reset
REQ-029 SHALL on rst force txd=1, busy=0, tx_done=0, full=0, empty=1, count=0, overflow=0, state IDLE, pointers 0.
REQ-030 SHALL on rst mid-frame abort the frame immediately (txd high asynchronously) and discard all queued data.

Structure
REQ-031 SHALL place FSM state enum and PARITY mode constants (PAR_NONE/ODD/EVEN) in shared package uart_pkg.
REQ-032 SHALL instantiate one sub-module sync_fifo (parametrised width/depth, full/empty/count) for buffering.
REQ-033 SHALL be 120-400 lines RTL, no latches, no derived clocks.

Verification
REQ-034 SHALL cover: CLK_DIV=4, 8N1, write 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each 4 cycles, tx_done at cycle 40 of frame.
REQ-035 SHALL cover: PARITY=2, write 0x07 -> parity bit 1; PARITY=1 same data -> parity bit 0.
REQ-036 SHALL cover: FIFO_DEPTH=4, write 6 consecutive cycles -> full after 4th, overflow=1, exactly 4 frames, one idle cycle between.
REQ-037 SHALL cover: rst asserted during DATA bit 3 -> txd=1 same cycle, count=0, no tx_done, no further frames.
REQ-038 SHALL cover: STOP_BITS=2, DATA_BITS=5, write 0x1F -> stop interval 2*CLK_DIV cycles, frame 8*CLK_DIV total.
REQ-039 SHALL cover: full FIFO, wr_en coincident with pop -> write dropped, count decrements to 3, overflow=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; depth must be a power of two so the
// pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Writes are refused whenever full, even if a pop frees a slot this cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a character FIFO; frames are start, LSB-first data,
// optional parity and one or two stop bits, all with a registered txd.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 434,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          txd
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(CLK_DIV - 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD_INV   = (PARITY == PAR_ODD);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 pop;

  assign pop = (state == IDLE) && !empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      // Registered pulse: raised one cycle early so it lands on the last STOP cycle.
      tx_done <= (state == STOP) && (cnt == CNT_DONE) && (bit_idx == STOP_LAST);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!empty) begin
            shift   <= fifo_rdata;
            par_bit <= (^fifo_rdata) ^ ODD_INV;
            txd     <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            txd     <= shift[0];
            shift   <= shift >> 1;
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != PAR_NONE) begin
                txd   <= par_bit;
                state <= PAR;
              end else begin
                txd   <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              txd     <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PAR: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, odd/even parity,
// 5-bit data with two stop bits, FIFO overflow and mid-frame reset.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // u0: 8N1, CLK_DIV 4, depth 4
  logic       wr_en0 = 1'b0;
  logic [7:0] wr_data0 = '0;
  logic       full0, empty0, overflow0, busy0, done0, txd0;
  logic [2:0] count0;

  // u1 even / u2 odd parity share stimulus
  logic       wr_en_p = 1'b0;
  logic [7:0] wr_data_p = '0;
  logic       full1, empty1, overflow1, busy1, done1, txd1;
  logic [4:0] count1;
  logic       full2, empty2, overflow2, busy2, done2, txd2;
  logic [4:0] count2;

  // u3: 5 data bits, 2 stop bits
  logic       wr_en3 = 1'b0;
  logic [4:0] wr_data3 = '0;
  logic       full3, empty3, overflow3, busy3, done3, txd3;
  logic [4:0] count3;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLK_DIV(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .full(full0), .empty(empty0),
    .count(count0), .overflow(overflow0), .busy(busy0), .tx_done(done0), .txd(txd0));

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .CLK_DIV(4), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en_p), .wr_data(wr_data_p), .full(full1), .empty(empty1),
    .count(count1), .overflow(overflow1), .busy(busy1), .tx_done(done1), .txd(txd1));

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .CLK_DIV(4), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en_p), .wr_data(wr_data_p), .full(full2), .empty(empty2),
    .count(count2), .overflow(overflow2), .busy(busy2), .tx_done(done2), .txd(txd2));

  uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(16), .CLK_DIV(4), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_data(wr_data3), .full(full3), .empty(empty3),
    .count(count3), .overflow(overflow3), .busy(busy3), .tx_done(done3), .txd(txd3));

  int n_pass  = 0;
  int n_total = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [9:0]  fr55;
  logic [10:0] fr_even, fr_odd;
  logic [7:0]  fr5;
  logic [7:0]  burst [6];
  logic [7:0]  rx;
  int          waited, seen_busy, seen_done, seen_low, b;

  initial begin
    fr55    = 10'b1_0101_0101_0;       // stop, 0x55, start (LSB = first on line)
    fr_even = 11'b1_1_0000_0111_0;     // stop, parity 1, 0x07, start
    fr_odd  = 11'b1_0_0000_0111_0;     // stop, parity 0, 0x07, start
    fr5     = 8'b11_11111_0;           // 2 stop, 0x1F, start
    burst   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99, 8'hAA};

    // Reset state
    tick; tick;
    chk("rst_txd0", txd0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_full0", full0, 0);
    chk("rst_empty0", empty0, 1);
    chk("rst_count0", count0, 0);
    chk("rst_ovf0", overflow0, 0);
    chk("rst_txd3", txd3, 1);
    rst = 1'b0;
    tick;

    // 8N1 0x55: entry visible next cycle, txd falls the cycle after
    wr_en0 = 1'b1; wr_data0 = 8'h55;
    tick;
    wr_en0 = 1'b0;
    chk("w55_empty", empty0, 0);
    chk("w55_count", count0, 1);
    chk("w55_txd_idle", txd0, 1);
    chk("w55_busy_idle", busy0, 0);
    tick;
    chk("w55_count_popped", count0, 0);
    chk("w55_busy", busy0, 1);
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) tick;
      chk("f55_txd", txd0, fr55[(c-1)/4]);
      chk("f55_done", done0, (c == 40));
    end
    tick;
    chk("f55_end_busy", busy0, 0);
    chk("f55_end_txd", txd0, 1);
    chk("f55_end_done", done0, 0);

    // Parity: even and odd on 0x07
    wr_en_p = 1'b1; wr_data_p = 8'h07;
    tick;
    wr_en_p = 1'b0;
    tick;
    for (int c = 1; c <= 44; c++) begin
      if (c > 1) tick;
      if ((c - 1) % 4 == 1) begin
        chk("par_even_txd", txd1, fr_even[(c-1)/4]);
        chk("par_odd_txd", txd2, fr_odd[(c-1)/4]);
      end
      if (c == 44) begin
        chk("par_even_done", done1, 1);
        chk("par_odd_done", done2, 1);
      end
    end
    tick;
    chk("par_end_busy", busy1, 0);

    // 5 data bits, 2 stop bits: frame 32 cycles, stop 8 cycles
    wr_en3 = 1'b1; wr_data3 = 5'h1F;
    tick;
    wr_en3 = 1'b0;
    tick;
    for (int c = 1; c <= 32; c++) begin
      if (c > 1) tick;
      chk("f5_txd", txd3, fr5[(c-1)/4]);
      chk("f5_done", done3, (c == 32));
      chk("f5_busy", busy3, 1);
    end
    tick;
    chk("f5_end_busy", busy3, 0);

    // Overflow: burst of 6 writes while a frame is in flight
    wr_en0 = 1'b1; wr_data0 = 8'h3C;
    tick;
    wr_en0 = 1'b0;
    tick;
    chk("ov_started", busy0, 1);
    for (int k = 0; k < 6; k++) begin
      wr_en0 = 1'b1; wr_data0 = burst[k];
      tick;
      chk("ov_count", count0, (k < 4) ? k + 1 : 4);
      chk("ov_full", full0, (k >= 3));
      chk("ov_flag", overflow0, (k >= 4));
    end
    wr_en0 = 1'b0;
    waited = 0;
    while (busy0 && waited < 60) begin
      tick;
      waited++;
    end
    chk("ov_idle_wait", (waited < 60), 1);
    chk("ov_full_at_pop", full0, 1);
    // write coincident with pop while full: dropped
    wr_en0 = 1'b1; wr_data0 = 8'hEE;
    tick;
    wr_en0 = 1'b0;
    chk("pop_full_count", count0, 3);
    chk("pop_full_ovf", overflow0, 1);
    chk("pop_full_full", full0, 0);
    chk("pop_full_busy", busy0, 1);
    for (int f = 0; f < 4; f++) begin
      rx = '0;
      for (int c = 1; c <= 40; c++) begin
        if (c > 1) tick;
        b = (c - 1) / 4;
        if ((c - 1) % 4 == 1 && b >= 1 && b <= 8) rx[b-1] = txd0;
        if (c == 40) chk("ov_frame_done", done0, 1);
      end
      chk("ov_frame_data", rx, burst[f]);
      tick;
      chk("ov_gap_busy", busy0, 0);
      chk("ov_gap_txd", txd0, 1);
      if (f < 3) begin
        tick;
        chk("ov_next_busy", busy0, 1);
      end
    end
    chk("ov_drained", empty0, 1);
    tick; tick;
    chk("ov_no_extra", busy0, 0);

    // Reset mid-frame during data bit 3 of 0x07, with one more entry queued
    wr_en0 = 1'b1; wr_data0 = 8'h07;
    tick;
    wr_data0 = 8'hF0;
    tick;
    wr_en0 = 1'b0;
    chk("rf_count_same", count0, 1);
    for (int c = 2; c <= 18; c++) tick;
    chk("rf_bit3_txd", txd0, 0);
    chk("rf_bit3_busy", busy0, 1);
    rst = 1'b1;
    #1;
    chk("rf_txd", txd0, 1);
    chk("rf_count", count0, 0);
    chk("rf_empty", empty0, 1);
    chk("rf_busy", busy0, 0);
    chk("rf_ovf", overflow0, 0);
    #1;
    rst = 1'b0;
    seen_busy = 0; seen_done = 0; seen_low = 0;
    for (int c = 0; c < 60; c++) begin
      tick;
      if (busy0) seen_busy++;
      if (done0) seen_done++;
      if (!txd0) seen_low++;
    end
    chk("rf_no_busy", seen_busy, 0);
    chk("rf_no_done", seen_done, 0);
    chk("rf_line_idle", seen_low, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
